hex_readback: RTL and testbench

- Reverse path of the seven-segment output stage: takes the eight active-low segment patterns driven onto the HEX displays and reconstructs the hex word they show.
- Sequential scanner behind a valid/ready request/response handshake.
- On request, snapshots all eight patterns, decodes one digit per scan slot, and returns a 32-bit word with per-digit blank/error flags.
- Used by the LSU readback path and by the verification harness to check the display contents.

---
 rtl/hex_readback_if.sv | 34 +++
 rtl/hex_readback.sv | 138 +++++++++++++
 tb/tb_hex_readback.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/hex_readback_if.sv
// Handshake, abort and segment-pattern bundle for hex_readback.
//   i_io_hex0..7 : active-low segment patterns (bit0=a .. bit6=g)
//   i_req_valid / o_req_ready : readback request handshake
//   i_abort : drops an in-flight scan
//   o_busy : scan in progress
//   o_rsp_valid / i_rsp_ready : response handshake
//   o_rsp_data / o_rsp_err / o_rsp_blank : decoded word and per-digit flags
interface hex_readback_if;
    logic [6:0]  i_io_hex0, i_io_hex1, i_io_hex2, i_io_hex3;
    logic [6:0]  i_io_hex4, i_io_hex5, i_io_hex6, i_io_hex7;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_abort;
    logic        o_busy;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic [7:0]  o_rsp_err;
    logic [7:0]  o_rsp_blank;

    modport master (
        output i_io_hex0, i_io_hex1, i_io_hex2, i_io_hex3,
               i_io_hex4, i_io_hex5, i_io_hex6, i_io_hex7,
               i_req_valid, i_abort, i_rsp_ready,
        input  o_req_ready, o_busy, o_rsp_valid, o_rsp_data, o_rsp_err, o_rsp_blank
    );

    modport slave (
        input  i_io_hex0, i_io_hex1, i_io_hex2, i_io_hex3,
               i_io_hex4, i_io_hex5, i_io_hex6, i_io_hex7,
               i_req_valid, i_abort, i_rsp_ready,
        output o_req_ready, o_busy, o_rsp_valid, o_rsp_data, o_rsp_err, o_rsp_blank
    );
endinterface

// File: rtl/hex_readback.sv
// hex_readback: reconstructs the hex word shown on eight seven-segment
// displays. A request snapshots all eight patterns, then one digit is decoded
// per slot of CYCLES_PER_DIGIT cycles; the word plus blank/error flags is
// returned through a valid/ready response.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : hex_readback_if.slave (patterns, request, abort, response)
module hex_readback #(
    parameter int CYCLES_PER_DIGIT = 1
) (
    input  logic           i_clk,
    input  logic           i_reset,
    hex_readback_if.slave  bus
);
    localparam int CW = (CYCLES_PER_DIGIT > 1) ? $clog2(CYCLES_PER_DIGIT) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [2:0]        idx;
    logic [7:0][6:0]   snap;
    logic [31:0]       acc_data, acc_data_n;
    logic [7:0]        acc_err, acc_err_n;
    logic [7:0]        acc_blank, acc_blank_n;
    logic [31:0]       rsp_data;
    logic [7:0]        rsp_err, rsp_blank;
    logic              last_slot, last_digit;
    logic [5:0]        dec;  // {err, blank, nibble}

    // Exact 7-bit match against the glyph set; anything else is an error.
    function automatic logic [5:0] decode(input logic [6:0] p);
        case (p)
            7'h40: decode = 6'h00;
            7'h79: decode = 6'h01;
            7'h24: decode = 6'h02;
            7'h30: decode = 6'h03;
            7'h19: decode = 6'h04;
            7'h12: decode = 6'h05;
            7'h02: decode = 6'h06;
            7'h78: decode = 6'h07;
            7'h00: decode = 6'h08;
            7'h10: decode = 6'h09;
            7'h08: decode = 6'h0A;
            7'h03: decode = 6'h0B;
            7'h46: decode = 6'h0C;
            7'h21: decode = 6'h0D;
            7'h06: decode = 6'h0E;
            7'h0E: decode = 6'h0F;
            7'h7F: decode = 6'b01_0000;
            default: decode = 6'b10_0000;
        endcase
    endfunction

    assign last_slot  = (cnt == CW'(CYCLES_PER_DIGIT - 1));
    assign last_digit = (idx == 3'd7);
    assign dec        = decode(snap[idx]);

    // Accumulators with the current digit merged in; used both for the
    // running state and, on the final digit, for the response registers.
    always_comb begin
        acc_data_n               = acc_data;
        acc_err_n                = acc_err;
        acc_blank_n              = acc_blank;
        acc_data_n[{idx, 2'b00} +: 4] = dec[3:0];
        acc_blank_n[idx]         = dec[4];
        acc_err_n[idx]           = dec[5];
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (bus.i_req_valid) state_n = SCAN;
            SCAN: begin
                if (bus.i_abort)                    state_n = IDLE;
                else if (last_slot && last_digit)   state_n = DONE;
            end
            DONE: if (bus.i_rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt       <= '0;
            idx       <= '0;
            snap      <= '0;
            acc_data  <= '0;
            acc_err   <= '0;
            acc_blank <= '0;
            rsp_data  <= '0;
            rsp_err   <= '0;
            rsp_blank <= '0;
        end else begin
            case (state)
                IDLE: if (bus.i_req_valid) begin
                    snap      <= {bus.i_io_hex7, bus.i_io_hex6, bus.i_io_hex5, bus.i_io_hex4,
                                  bus.i_io_hex3, bus.i_io_hex2, bus.i_io_hex1, bus.i_io_hex0};
                    acc_data  <= '0;
                    acc_err   <= '0;
                    acc_blank <= '0;
                    cnt       <= '0;
                    idx       <= '0;
                end
                SCAN: if (!bus.i_abort) begin
                    if (last_slot) begin
                        cnt       <= '0;
                        idx       <= idx + 3'd1;
                        acc_data  <= acc_data_n;
                        acc_err   <= acc_err_n;
                        acc_blank <= acc_blank_n;
                        if (last_digit) begin
                            rsp_data  <= acc_data_n;
                            rsp_err   <= acc_err_n;
                            rsp_blank <= acc_blank_n;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_req_ready = (state == IDLE);
    assign bus.o_busy      = (state == SCAN);
    assign bus.o_rsp_valid = (state == DONE);
    assign bus.o_rsp_data  = rsp_data;
    assign bus.o_rsp_err   = rsp_err;
    assign bus.o_rsp_blank = rsp_blank;
endmodule

// File: tb/tb_hex_readback.sv
module tb_hex_readback;
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  err;
        logic [7:0]  blank;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hex_readback_if if1 ();
    hex_readback_if if3 ();
    logic [7:0][6:0] hex1, hex3;

    assign if1.i_io_hex0 = hex1[0]; assign if1.i_io_hex1 = hex1[1];
    assign if1.i_io_hex2 = hex1[2]; assign if1.i_io_hex3 = hex1[3];
    assign if1.i_io_hex4 = hex1[4]; assign if1.i_io_hex5 = hex1[5];
    assign if1.i_io_hex6 = hex1[6]; assign if1.i_io_hex7 = hex1[7];
    assign if3.i_io_hex0 = hex3[0]; assign if3.i_io_hex1 = hex3[1];
    assign if3.i_io_hex2 = hex3[2]; assign if3.i_io_hex3 = hex3[3];
    assign if3.i_io_hex4 = hex3[4]; assign if3.i_io_hex5 = hex3[5];
    assign if3.i_io_hex6 = hex3[6]; assign if3.i_io_hex7 = hex3[7];

    hex_readback #(.CYCLES_PER_DIGIT(1)) u1 (.i_clk(clk), .i_reset(rst_n), .bus(if1));
    hex_readback #(.CYCLES_PER_DIGIT(3)) u3 (.i_clk(clk), .i_reset(rst_n), .bus(if3));

    int checks = 0;
    int errors = 0;
    rsp_t q1[$];
    rsp_t q3[$];

    // Segment glyph for each hex value 0..F (active low, bit0=a).
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic rsp_t model(input logic [7:0][6:0] p);
        rsp_t r = '0;
        for (int k = 0; k < 8; k++) begin
            if (p[k] == 7'h7F) r.blank[k] = 1'b1;
            else begin
                bit found = 1'b0;
                for (int v = 0; v < 16; v++)
                    if (glyph[v] == p[k]) begin
                        r.data[4*k +: 4] = 4'(v);
                        found = 1'b1;
                    end
                if (!found) r.err[k] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] rand_pat();
        int s = $urandom_range(0, 9);
        if (s < 6)       return glyph[$urandom_range(0, 15)];
        else if (s < 8)  return 7'h7F;
        else             return 7'($urandom);
    endfunction

    function automatic logic [7:0][6:0] rand_pats();
        logic [7:0][6:0] p;
        for (int k = 0; k < 8; k++) p[k] = rand_pat();
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic rsp_t out_of(input bit s);
        rsp_t r;
        if (s) r = '{if3.o_rsp_data, if3.o_rsp_err, if3.o_rsp_blank};
        else   r = '{if1.o_rsp_data, if1.o_rsp_err, if1.o_rsp_blank};
        return r;
    endfunction
    function automatic logic vld(input bit s);   return s ? if3.o_rsp_valid : if1.o_rsp_valid; endfunction
    function automatic logic rdy(input bit s);   return s ? if3.o_req_ready : if1.o_req_ready; endfunction
    function automatic logic busy(input bit s);  return s ? if3.o_busy : if1.o_busy; endfunction

    task automatic set_req(input bit s, input logic v);
        if (s) if3.i_req_valid = v; else if1.i_req_valid = v;
    endtask
    task automatic set_rsp_rdy(input bit s, input logic v);
        if (s) if3.i_rsp_ready = v; else if1.i_rsp_ready = v;
    endtask
    task automatic set_hex(input bit s, input logic [7:0][6:0] p);
        if (s) hex3 = p; else hex1 = p;
    endtask

    // Scoreboard monitors: pop on every response handshake.
    always @(negedge clk) begin
        if (if1.o_rsp_valid && if1.i_rsp_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp1_unexpected: got data %h with no request outstanding", if1.o_rsp_data);
            end else chk("rsp1", 64'(out_of(1'b0)), 64'(q1.pop_front()));
        end
        if (if3.o_rsp_valid && if3.i_rsp_ready) begin
            if (q3.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp3_unexpected: got data %h with no request outstanding", if3.o_rsp_data);
            end else chk("rsp3", 64'(out_of(1'b1)), 64'(q3.pop_front()));
        end
    end

    // One request: check latency, optional response hold, and return to IDLE.
    task automatic run_req(input bit s, input logic [7:0][6:0] p, input bit change_after, input int hold);
        rsp_t e = model(p);
        int n = 0;
        int lat = s ? 24 : 8;
        @(negedge clk);
        chk("req_ready_before", 64'(rdy(s)), 64'd1);
        set_hex(s, p);
        set_req(s, 1'b1);
        set_rsp_rdy(s, 1'b0);
        if (s) q3.push_back(e); else q1.push_back(e);
        @(posedge clk); #1;
        set_req(s, 1'b0);
        if (change_after) set_hex(s, {8{7'h7F}});
        while (!vld(s) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 64'(n), 64'(lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(vld(s)), 64'd1);
            chk("hold_data", 64'(out_of(s)), 64'(e));
        end
        set_rsp_rdy(s, 1'b1);
        @(posedge clk); #1;
        chk("idle_ready", 64'(rdy(s)), 64'd1);
        chk("idle_valid", 64'(vld(s)), 64'd0);
        set_rsp_rdy(s, 1'b0);
    endtask

    initial begin
        rsp_t last3;
        int last_acc;
        hex1 = '0; hex3 = '0;
        if1.i_req_valid = 0; if1.i_abort = 0; if1.i_rsp_ready = 0;
        if3.i_req_valid = 0; if3.i_abort = 0; if3.i_rsp_ready = 0;
        #12;
        chk("rst_out1", 64'(out_of(1'b0)), 64'd0);
        chk("rst_out3", 64'(out_of(1'b1)), 64'd0);
        chk("rst_flags1", {61'd0, if1.o_req_ready, if1.o_busy, if1.o_rsp_valid}, 64'b100);
        chk("rst_flags3", {61'd0, if3.o_req_ready, if3.o_busy, if3.o_rsp_valid}, 64'b100);
        @(negedge clk); rst_n = 1'b1;

        // Directed patterns on the single-cycle-slot instance.
        run_req(1'b0, {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 1'b0, 0);
        run_req(1'b0, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00}, 1'b0, 0);
        run_req(1'b0, {7'h40, 7'h40, 7'h7E, 7'h40, 7'h7F, 7'h40, 7'h40, 7'h40}, 1'b0, 0);
        run_req(1'b0, {7'h21, 7'h10, 7'h02, 7'h46, 7'h79, 7'h08, 7'h30, 7'h0E}, 1'b1, 5);
        for (int i = 0; i < 6; i++) run_req(1'b0, rand_pats(), 1'b0, $urandom_range(0, 2));

        // Three-cycle slots.
        for (int i = 0; i < 4; i++) run_req(1'b1, rand_pats(), i[0], $urandom_range(0, 2));
        last3 = model(hex3);
        run_req(1'b1, {7'h19, 7'h12, 7'h79, 7'h0E, 7'h40, 7'h24, 7'h06, 7'h03}, 1'b0, 0);
        last3 = model({7'h19, 7'h12, 7'h79, 7'h0E, 7'h40, 7'h24, 7'h06, 7'h03});

        // Abort mid-scan: no response, previous outputs retained.
        @(negedge clk);
        hex3 = rand_pats();
        if3.i_req_valid = 1; if3.i_rsp_ready = 1;
        @(posedge clk); #1;
        if3.i_req_valid = 0;
        for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
        chk("abort_busy_before", 64'(if3.o_busy), 64'd1);
        if3.i_abort = 1;
        @(posedge clk); #1;
        if3.i_abort = 0;
        chk("abort_idle", {62'd0, if3.o_req_ready, if3.o_busy}, 64'b10);
        chk("abort_keep", 64'(out_of(1'b1)), 64'(last3));
        for (int i = 0; i < 30; i++) begin @(posedge clk); #1; end
        chk("abort_no_valid", 64'(if3.o_rsp_valid), 64'd0);
        if3.i_rsp_ready = 0;

        // Back-to-back requests with valid and ready both held high.
        if1.i_req_valid = 1; if1.i_rsp_ready = 1;
        last_acc = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            hex1 = rand_pats();
            if (if1.o_busy && if1.o_req_ready) begin
                checks++; errors++;
                $display("FAIL busy_ready: got busy=1 ready=1 required not both");
            end
            if (if1.o_req_ready) begin
                q1.push_back(model(hex1));
                if (last_acc >= 0) chk("b2b_spacing", 64'(c - last_acc), 64'd10);
                last_acc = c;
            end
        end
        @(negedge clk);
        if1.i_req_valid = 0;
        for (int i = 0; i < 20; i++) @(posedge clk);
        if1.i_rsp_ready = 0;

        // Async reset mid-scan.
        @(negedge clk);
        hex3 = rand_pats();
        if3.i_req_valid = 1; if3.i_rsp_ready = 1;
        @(posedge clk); #1;
        if3.i_req_valid = 0;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("areset_out3", 64'(out_of(1'b1)), 64'd0);
        chk("areset_out1", 64'(out_of(1'b0)), 64'd0);
        chk("areset_flags3", {61'd0, if3.o_req_ready, if3.o_busy, if3.o_rsp_valid}, 64'b100);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", 64'(if3.o_req_ready), 64'd1);
        for (int i = 0; i < 30; i++) begin @(posedge clk); #1; end
        chk("post_reset_no_valid", 64'(if3.o_rsp_valid), 64'd0);
        if3.i_rsp_ready = 0;
        run_req(1'b1, rand_pats(), 1'b0, 1);

        @(negedge clk);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q3_drained", 64'(q3.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
